router_sync_n: RTL and testbench

Parametrised synchroniser between the router FSM, register block and NUM_CH output FIFOs.
- Latches the destination address on header detect.
- Drives a one-hot FIFO write enable and muxes back the selected FIFO's full flag.
- Generates per-channel valid-out.
- Issues a per-channel soft-reset pulse when a non-empty FIFO goes unread for TIMEOUT cycles.
- Generalises the fixed 3-channel, 30-cycle sync block. All outputs are X-free and the full-flag mux covers every channel.

---
 rtl/router_sync_n.sv | 95 +++++++++
 tb/tb_router_sync_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// Synchroniser between the router FSM, register block and NUM_CH output FIFOs.
// Optional per-channel soft-reset drop counter is enabled by ROUTER_SYNC_DROP_CNT_EN.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                detect_add,
  input  logic                write_enb_reg,
  input  logic [ADDR_W-1:0]   data_in,
  input  logic [NUM_CH-1:0]   read_enb,
  input  logic [NUM_CH-1:0]   empty,
  input  logic [NUM_CH-1:0]   full,
  output logic [NUM_CH-1:0]   vld_out,
  output logic [NUM_CH-1:0]   write_enb,
  output logic                fifo_full,
  output logic                addr_valid,
`ifdef ROUTER_SYNC_DROP_CNT_EN
  output logic [NUM_CH*8-1:0] drop_cnt,
`endif
  output logic [NUM_CH-1:0]   soft_reset
);

  // NUM_CH always fits in ADDR_W+1 bits because 2**ADDR_W >= NUM_CH.
  localparam logic [ADDR_W:0]  NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] fifo_addr_reg;
  logic              addr_valid_reg;
  logic [NUM_CH-1:0] addr_hit;
  logic [NUM_CH-1:0] soft_reset_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      fifo_addr_reg  <= '0;
      addr_valid_reg <= 1'b0;
    end else if (detect_add) begin
      fifo_addr_reg  <= data_in;
      addr_valid_reg <= ({1'b0, data_in} < NUM_CH_W);
    end
  end

  // Out-of-range addresses match no channel, so both the write decode and
  // the full mux collapse to zero whenever addr_valid is low.
  assign write_enb  = {NUM_CH{write_enb_reg & addr_valid_reg}} & addr_hit;
  assign fifo_full  = addr_valid_reg & (|(full & addr_hit));
  assign addr_valid = addr_valid_reg;
  assign soft_reset = soft_reset_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic             idle;
      logic             expire;

      assign addr_hit[gi] = (fifo_addr_reg == ADDR_W'(gi));
      assign vld_out[gi]  = ~empty[gi];
      assign idle         = ~empty[gi] & ~read_enb[gi];
      assign expire       = idle & (cnt_reg == CNT_LAST);

      always_ff @(posedge clock) begin
        if (!resetn) begin
          cnt_reg            <= '0;
          soft_reset_reg[gi] <= 1'b0;
        end else begin
          soft_reset_reg[gi] <= expire;
          if (!idle || expire) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

`ifdef ROUTER_SYNC_DROP_CNT_EN
      logic [7:0] drop_reg;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          drop_reg <= '0;
        end else if (expire && (drop_reg != 8'hFF)) begin
          drop_reg <= drop_reg + 8'd1;
        end
      end

      assign drop_cnt[gi*8 +: 8] = drop_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_router_sync_n.sv
// Randomised and directed bench for router_sync_n against a cycle-level
// behavioural model of address latching, write decode and idle timeouts.
module tb_router_sync_n;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 8;

  logic                clock = 1'b0;
  logic                resetn;
  logic                detect_add;
  logic                write_enb_reg;
  logic [ADDR_W-1:0]   data_in;
  logic [NUM_CH-1:0]   read_enb;
  logic [NUM_CH-1:0]   empty;
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   vld_out;
  logic [NUM_CH-1:0]   write_enb;
  logic                fifo_full;
  logic                addr_valid;
  logic [NUM_CH-1:0]   soft_reset;
`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [NUM_CH*8-1:0] drop_cnt;
`endif

  router_sync_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .detect_add(detect_add),
    .write_enb_reg(write_enb_reg),
    .data_in(data_in),
    .read_enb(read_enb),
    .empty(empty),
    .full(full),
    .vld_out(vld_out),
    .write_enb(write_enb),
    .fifo_full(fifo_full),
    .addr_valid(addr_valid),
`ifdef ROUTER_SYNC_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: latched address, consecutive idle edges since the last
  // non-idle edge or pulse, expected pulses and pulse tallies.
  int                m_addr;
  bit                m_valid;
  int                m_run  [NUM_CH];
  int                m_drop [NUM_CH];
  logic [NUM_CH-1:0] m_sr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr  = 0;
    m_valid = 1'b0;
    m_sr    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c]  = 0;
      m_drop[c] = 0;
    end
  endtask

  task automatic model_edge();
    if (!resetn) begin
      model_reset();
    end else begin
      if (detect_add) begin
        m_addr  = int'(data_in);
        m_valid = (m_addr < NUM_CH);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        m_sr[c] = 1'b0;
        if (!empty[c] && !read_enb[c]) begin
          m_run[c]++;
          if (m_run[c] == TIMEOUT) begin
            m_sr[c]  = 1'b1;
            m_run[c] = 0;
            if (m_drop[c] < 255) m_drop[c]++;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
  endtask

  // Inputs are already applied (just after a falling edge); check, then clock.
  task automatic step();
    logic [NUM_CH-1:0] exp_vld;
    logic [NUM_CH-1:0] exp_we;
    logic              exp_ff;
    #1;
    exp_vld = ~empty;
    exp_we  = '0;
    if (write_enb_reg && m_valid) exp_we[m_addr] = 1'b1;
    exp_ff  = m_valid ? full[m_addr] : 1'b0;
    check_eq("vld_out",    vld_out,    exp_vld);
    check_eq("write_enb",  write_enb,  exp_we);
    check_eq("fifo_full",  fifo_full,  exp_ff);
    check_eq("addr_valid", addr_valid, m_valid);
    check_eq("soft_reset", soft_reset, m_sr);
`ifdef ROUTER_SYNC_DROP_CNT_EN
    for (int c = 0; c < NUM_CH; c++) check_eq("drop_cnt", drop_cnt[c*8 +: 8], 8'(m_drop[c]));
`endif
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic drive(input logic rn, input logic da, input logic wr, input logic [ADDR_W-1:0] din,
                       input logic [NUM_CH-1:0] rd, input logic [NUM_CH-1:0] em, input logic [NUM_CH-1:0] fu);
    resetn = rn; detect_add = da; write_enb_reg = wr; data_in = din;
    read_enb = rd; empty = em; full = fu;
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '1, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '1, '0);
  endtask

  initial begin
    resetn = 1'b0; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = '0;
    read_enb = '0; empty = '1; full = '0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state and valid address decode
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 2'd2, '0, '1, '0);
    drive(1'b1, 1'b0, 1'b1, 2'd0, '0, '1, 3'b100);
    drive(1'b1, 1'b0, 1'b1, 2'd0, '0, '1, 3'b011);
    drive(1'b1, 1'b1, 1'b1, 2'd0, '0, '1, 3'b100);
    drive(1'b1, 1'b0, 1'b1, 2'd1, '0, '1, 3'b010);
    $display("txn addr_decode: write_enb=%b fifo_full=%b", write_enb, fifo_full);

    // Out-of-range address
    drive(1'b1, 1'b1, 1'b0, 2'd3, '0, '1, '0);
    for (int f = 0; f < 8; f++) drive(1'b1, 1'b0, 1'b1, 2'd0, '0, '1, 3'(f));
    $display("txn addr_invalid: addr_valid=%b", addr_valid);

    // Channel 0 timeout, repeated pulse
    do_reset();
    repeat (2 * TIMEOUT + 2) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b110, '0);
    $display("txn timeout_ch0: soft_reset=%b", soft_reset);

    // Channel 1 read on idle edge 29 blocks the pulse
    do_reset();
    repeat (TIMEOUT - 2) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b101, '0);
    drive(1'b1, 1'b0, 1'b0, '0, 3'b010, 3'b101, '0);
    repeat (TIMEOUT + 2) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b101, '0);
    $display("txn read_saves_ch1: soft_reset=%b", soft_reset);

    // Reset in mid-count on channels 0 and 2
    do_reset();
    repeat (15) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b010, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b010, '0);
    repeat (TIMEOUT + 2) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b010, '0);
    $display("txn reset_midcount: soft_reset=%b", soft_reset);

    // Channel 1: 3 timeouts, then enough to saturate the tally
    do_reset();
    repeat (3 * TIMEOUT + 1) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b101, '0);
    $display("txn drop_three: runs=%0d", m_drop[1]);
    repeat (256 * TIMEOUT + 5) drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b101, '0);
    $display("txn drop_saturate: runs=%0d", m_drop[1]);

    // Random traffic; reads are sparse so timeouts actually occur
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 400; k++) begin
        logic [NUM_CH-1:0] rd, em;
        for (int c = 0; c < NUM_CH; c++) begin
          rd[c] = ($urandom_range(0, 39) == 0);
          em[c] = ($urandom_range(0, 19) == 0);
        end
        drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), 1'($urandom),
              ADDR_W'($urandom), rd, em, NUM_CH'($urandom));
      end
      $display("txn random_batch %0d: compared so far %0d", b, n_cmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
